// File: rtl/indexed_array_bank_if.sv
// Handshake/data bundle for indexed_array_bank.
// Master drives requests, slave returns read data and status.
interface indexed_array_bank_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
);
  localparam int AW = $clog2(DEPTH);

  logic             in_wr_en;
  logic [31:0]      in_index;
  logic [WIDTH-1:0] in_array_val;
  logic             in_rd_en;
  logic [31:0]      in_rd_index;
  logic             in_clear_start;
  logic [WIDTH-1:0] out_rd_val;
  logic             out_rd_valid;
  logic             out_busy;
  logic             out_clear_done;
  logic [AW:0]      out_wr_count;

  modport master (
    output in_wr_en, in_index, in_array_val,
    output in_rd_en, in_rd_index, in_clear_start,
    input  out_rd_val, out_rd_valid, out_busy,
    input  out_clear_done, out_wr_count
  );

  modport slave (
    input  in_wr_en, in_index, in_array_val,
    input  in_rd_en, in_rd_index, in_clear_start,
    output out_rd_val, out_rd_valid, out_busy,
    output out_clear_done, out_wr_count
  );
endinterface

// File: rtl/indexed_array_bank.sv
// DEPTH x WIDTH storage with modulo-indexed write/read ports,
// offset-on-write and a one-entry-per-cycle clear engine.
module indexed_array_bank #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 8,
  parameter int OFFSET = -1
) (
  input logic clk,
  input logic rst,
  indexed_array_bank_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [WIDTH-1:0] OFF  = WIDTH'(OFFSET);
  localparam logic [AW-1:0]    LAST = AW'(DEPTH - 1);
  localparam logic [AW:0]      FULL = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    ptr;
  logic [AW-1:0]    wr_addr;
  logic [AW-1:0]    rd_addr;
  logic [WIDTH-1:0] wdata;

  // Upper index bits are discarded by the modulo reduction.
  logic unused_idx;
  assign unused_idx = ^{bus.in_index[31:AW],
                        bus.in_rd_index[31:AW]};

  assign wr_addr = bus.in_index[AW-1:0];
  assign rd_addr = bus.in_rd_index[AW-1:0];
  assign wdata   = bus.in_array_val + OFF;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      state              <= IDLE;
      ptr                <= '0;
      bus.out_rd_val     <= '0;
      bus.out_rd_valid   <= 1'b0;
      bus.out_busy       <= 1'b0;
      bus.out_clear_done <= 1'b0;
      bus.out_wr_count   <= '0;
    end else begin
      bus.out_rd_valid <= bus.in_rd_en;
      // Read samples the array before any write on this edge.
      if (bus.in_rd_en)
        bus.out_rd_val <= (state == IDLE) ? mem[rd_addr] : '0;
      unique case (state)
        IDLE: begin
          if (bus.in_clear_start) begin
            state        <= CLEAR;
            ptr          <= '0;
            bus.out_busy <= 1'b1;
          end else if (bus.in_wr_en) begin
            mem[wr_addr] <= wdata;
            if (bus.out_wr_count != FULL)
              bus.out_wr_count <= bus.out_wr_count + 1'b1;
          end
        end
        CLEAR: begin
          mem[ptr] <= '0;
          ptr      <= ptr + 1'b1;
          if (ptr == LAST) begin
            state              <= DONE;
            bus.out_busy       <= 1'b0;
            bus.out_clear_done <= 1'b1;
          end
        end
        DONE: begin
          state              <= IDLE;
          bus.out_clear_done <= 1'b0;
          bus.out_wr_count   <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_indexed_array_bank.sv
// Randomised bench for indexed_array_bank with a behavioural model
// plus directed literal checks; a second instance covers wide params.
module tb_indexed_array_bank;
  localparam int D1 = 8;
  localparam int O1 = -1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  indexed_array_bank_if #(.WIDTH(8),  .DEPTH(8))  b1 ();
  indexed_array_bank_if #(.WIDTH(16), .DEPTH(16)) b2 ();

  indexed_array_bank #(.WIDTH(8), .DEPTH(8), .OFFSET(-1)) dut1 (
    .clk(clk), .rst(rst), .bus(b1)
  );
  indexed_array_bank #(.WIDTH(16), .DEPTH(16), .OFFSET(3)) dut2 (
    .clk(clk), .rst(rst), .bus(b2)
  );

  int checks = 0;
  int failures = 0;
  bit chk_on = 1'b0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t",
               name, act, exp, $time);
    end
  endtask

  // Behavioural model: clear seen as a cycle countdown, array zeroed at once
  int unsigned m_mem [D1];
  int unsigned e_rd_val = 0;
  int unsigned e_count = 0;
  bit e_rd_valid = 0, e_busy = 0, e_done = 0, blocked;
  int clr_left = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < D1; i++) m_mem[i] = 0;
      e_rd_val = 0; e_rd_valid = 0; e_busy = 0;
      e_done = 0; e_count = 0; clr_left = 0;
    end else begin
      blocked = (clr_left > 0) || e_done;
      e_rd_valid = b1.in_rd_en;
      if (b1.in_rd_en)
        e_rd_val = blocked ? 0 : m_mem[b1.in_rd_index % D1];
      if (clr_left > 0) begin
        clr_left--;
        e_done = (clr_left == 0);
      end else if (e_done) begin
        e_done = 0;
        e_count = 0;
      end else if (b1.in_clear_start) begin
        clr_left = D1;
        for (int i = 0; i < D1; i++) m_mem[i] = 0;
      end else if (b1.in_wr_en) begin
        m_mem[b1.in_index % D1] = (int'(b1.in_array_val) + O1) & 'hFF;
        if (e_count < D1) e_count++;
      end
      e_busy = clr_left > 0;
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("cyc_rd_valid", 32'(b1.out_rd_valid), 32'(e_rd_valid));
      chk("cyc_rd_val", 32'(b1.out_rd_val), e_rd_val);
      chk("cyc_busy", 32'(b1.out_busy), 32'(e_busy));
      chk("cyc_clear_done", 32'(b1.out_clear_done), 32'(e_done));
      chk("cyc_wr_count", 32'(b1.out_wr_count), e_count);
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle1();
    b1.in_wr_en = 0; b1.in_index = 0; b1.in_array_val = 0;
    b1.in_rd_en = 0; b1.in_rd_index = 0; b1.in_clear_start = 0;
  endtask

  task automatic idle2();
    b2.in_wr_en = 0; b2.in_index = 0; b2.in_array_val = 0;
    b2.in_rd_en = 0; b2.in_rd_index = 0; b2.in_clear_start = 0;
  endtask

  task automatic wr(input logic [31:0] idx, input logic [7:0] val);
    b1.in_wr_en = 1; b1.in_index = idx; b1.in_array_val = val;
    tick();
    idle1();
  endtask

  task automatic rd(input logic [31:0] idx);
    b1.in_rd_en = 1; b1.in_rd_index = idx;
    tick();
    idle1();
  endtask

  int busy_cycles, done_pulses;

  initial begin
    idle1();
    idle2();
    tick();
    chk("reset_rd_val", 32'(b1.out_rd_val), 0);
    chk("reset_rd_valid", 32'(b1.out_rd_valid), 0);
    chk("reset_wr_count", 32'(b1.out_wr_count), 0);
    chk("reset_busy", 32'(b1.out_busy), 0);
    chk_on = 1;
    rst = 0;
    tick();

    wr(3, 8'h10);
    rd(3);
    chk("t1_rd_val", 32'(b1.out_rd_val), 32'h0F);
    chk("t1_rd_valid", 32'(b1.out_rd_valid), 1);
    chk("t1_wr_count", 32'(b1.out_wr_count), 1);
    tick();
    chk("t1_valid_drop", 32'(b1.out_rd_valid), 0);

    wr(11, 8'h00);
    rd(-5);
    chk("t2_wrap", 32'(b1.out_rd_val), 32'hFF);

    wr(5, 8'h08);
    b1.in_wr_en = 1; b1.in_index = 5; b1.in_array_val = 8'h42;
    b1.in_rd_en = 1; b1.in_rd_index = 5;
    tick();
    idle1();
    chk("t3_rbw_old", 32'(b1.out_rd_val), 32'h07);
    rd(5);
    chk("t3_rbw_new", 32'(b1.out_rd_val), 32'h41);

    for (int i = 0; i < 10; i++) wr(i, 8'($urandom));
    chk("t4_count_sat", 32'(b1.out_wr_count), 8);
    b1.in_clear_start = 1;
    b1.in_wr_en = 1; b1.in_index = 0; b1.in_array_val = 8'h99;
    tick();
    idle1();
    busy_cycles = 0;
    for (int n = 0; n < 20 && b1.out_busy; n++) begin
      busy_cycles++;
      b1.in_wr_en = 1; b1.in_index = n; b1.in_array_val = 8'hA5;
      b1.in_rd_en = 1; b1.in_rd_index = 1;
      b1.in_clear_start = 1;
      tick();
      idle1();
    end
    chk("t4_busy_cycles", busy_cycles, 8);
    chk("t4_done_pulse", 32'(b1.out_clear_done), 1);
    chk("t4_count_frozen", 32'(b1.out_wr_count), 8);
    done_pulses = 0;
    for (int n = 0; n < 4; n++) begin
      tick();
      if (b1.out_clear_done) done_pulses++;
    end
    chk("t4_done_once", done_pulses, 0);
    chk("t4_count_zero", 32'(b1.out_wr_count), 0);
    for (int i = 0; i < 8; i++) begin
      rd(i);
      chk("t4_cleared", 32'(b1.out_rd_val), 0);
    end

    wr(3, 8'h33);
    rd(3);
    b1.in_clear_start = 1;
    tick();
    idle1();
    for (int n = 0; n < 3; n++) tick();
    chk("t5_busy_pre", 32'(b1.out_busy), 1);
    #2 rst = 1;
    #1;
    chk("t5_async_busy", 32'(b1.out_busy), 0);
    chk("t5_async_rd_val", 32'(b1.out_rd_val), 0);
    chk("t5_async_count", 32'(b1.out_wr_count), 0);
    chk("t5_async_done", 32'(b1.out_clear_done), 0);
    tick();
    rst = 0;
    for (int n = 0; n < 10; n++) tick();
    wr(0, 8'h05);
    rd(0);
    chk("t5_after_rst", 32'(b1.out_rd_val), 32'h04);
    rd(3);
    chk("t5_mem_zeroed", 32'(b1.out_rd_val), 0);

    for (int n = 0; n < 600; n++) begin
      b1.in_wr_en = ($urandom_range(0, 99) < 50);
      b1.in_index = $urandom;
      b1.in_array_val = 8'($urandom);
      b1.in_rd_en = ($urandom_range(0, 99) < 50);
      b1.in_rd_index = $urandom;
      b1.in_clear_start = ($urandom_range(0, 99) < 3);
      tick();
    end
    idle1();
    for (int n = 0; n < 12; n++) tick();

    b2.in_wr_en = 1; b2.in_index = 31; b2.in_array_val = 16'hFFFE;
    tick();
    idle2();
    b2.in_rd_en = 1; b2.in_rd_index = 15;
    tick();
    idle2();
    chk("t6_wide_val", 32'(b2.out_rd_val), 32'h0001);
    chk("t6_wide_valid", 32'(b2.out_rd_valid), 1);
    chk("t6_wide_count", 32'(b2.out_wr_count), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
